// File: rtl/sd_card_cmd_responder.sv
// -----------------------------------------------------------------------------
// sd_card_cmd_responder
//
// Card-side CMD line engine. Receives a 48-bit host command and validates its
// framing and CRC7. The decoded command goes to a card-behaviour model, and
// the response that model offers (48-bit or 136-bit) is sent back on CMD.
// All bit timing follows the host divider strobes: CMD is sampled on
// clk_en_p_i and driven on clk_en_n_i. Both strobes may be high together.
//
// Ports:
//   clk_i, rst_ni              system clock, synchronous active-low reset
//   clk_en_p_i / clk_en_n_i    SD clock rising / falling edge strobes
//   sd_cmd_i                   CMD line input
//   sd_cmd_o, sd_cmd_en_o      CMD line output value and output enable
//   cmd_valid_o / cmd_err_o    one-cycle pulses: good command / bad frame
//   cmd_o, cmd_arg_o           last good command index and argument
//   rsp_valid_i / rsp_ready_o  response handshake
//   rsp_long_i, rsp_no_crc_i   R2 (136-bit) select, CRC field forced to 7'h7F
//   rsp_i                      response payload
//   rsp_timeout_o              one-cycle pulse: no response offered in time
// -----------------------------------------------------------------------------
module sd_card_cmd_responder #(
    parameter int RSP_DELAY   = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_en_p_i,
    input  logic         clk_en_n_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_en_o,
    output logic         cmd_valid_o,
    output logic         cmd_err_o,
    output logic [5:0]   cmd_o,
    output logic [31:0]  cmd_arg_o,
    input  logic         rsp_valid_i,
    output logic         rsp_ready_o,
    input  logic         rsp_long_i,
    input  logic         rsp_no_crc_i,
    input  logic [119:0] rsp_i,
    output logic         rsp_timeout_o
);

    localparam logic [6:0] LP_DELAY   = 7'(RSP_DELAY);
    localparam logic [6:0] LP_TIMEOUT = 7'(RSP_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX       = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_TX       = 3'd4
    } state_t;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // CRC7 over the 40 leading bits of a command frame, MSB first, init 0
    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [6:0]     r_dly_cnt, w_dly_cnt_nxt;
    logic [47:0]    r_rx_sr, w_rx_sr_nxt;
    logic [5:0]     r_cmd, w_cmd_nxt;
    logic [31:0]    r_arg, w_arg_nxt;
    logic           r_cmd_valid, w_cmd_valid_nxt;
    logic           r_cmd_err, w_cmd_err_nxt;
    logic           r_timeout, w_timeout_nxt;
    logic           r_rsp_ready, w_rsp_ready_nxt;
    logic           r_latched, w_latched_nxt;
    logic           r_long, w_long_nxt;
    logic           r_no_crc, w_no_crc_nxt;
    logic [127:0]   r_tx_sr, w_tx_sr_nxt;
    logic [6:0]     r_crc, w_crc_nxt;
    logic           r_sd_cmd, w_sd_cmd_nxt;
    logic           r_sd_cmd_en, w_sd_cmd_en_nxt;

    logic           w_frame_ok;
    logic           w_hs;
    logic [7:0]     w_data_len;
    logic [7:0]     w_frame_len;
    logic           w_tx_bit;
    logic [127:0]   w_tx_sr_shift;
    logic [6:0]     w_crc_upd;

    // Received frame check: transmission bit, CRC7 over bits 47:8, end bit
    assign w_frame_ok = r_rx_sr[46] && (crc7_40(r_rx_sr[47:8]) == r_rx_sr[7:1]) && r_rx_sr[0];
    assign w_hs       = rsp_valid_i & r_rsp_ready;

    // Next transmit bit for the bit index in r_bit_cnt; CRC accumulates while shifting
    always_comb begin
        w_data_len    = r_long ? 8'd128 : 8'd40;
        w_frame_len   = r_long ? 8'd136 : 8'd48;
        w_tx_bit      = 1'b1;
        w_tx_sr_shift = r_tx_sr;
        w_crc_upd     = r_crc;
        if (r_bit_cnt < w_data_len) begin
            w_tx_bit      = r_tx_sr[127];
            w_tx_sr_shift = {r_tx_sr[126:0], 1'b0};
            // R2 CRC covers the CID/CSD payload only, not start/dir/header bits
            if (!r_long || (r_bit_cnt >= 8'd8)) begin
                w_crc_upd = crc7_step(r_crc, r_tx_sr[127]);
            end else begin
                w_crc_upd = r_crc;
            end
        end else if (r_bit_cnt < (w_data_len + 8'd7)) begin
            w_tx_bit  = r_no_crc ? 1'b1 : r_crc[6];
            w_crc_upd = {r_crc[5:0], 1'b0};
        end else begin
            w_tx_bit  = 1'b1;
        end
    end

    // FSM next-state and datapath next values
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_dly_cnt_nxt    = r_dly_cnt;
        w_rx_sr_nxt      = r_rx_sr;
        w_cmd_nxt        = r_cmd;
        w_arg_nxt        = r_arg;
        w_cmd_valid_nxt  = 1'b0;
        w_cmd_err_nxt    = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_rsp_ready_nxt  = r_rsp_ready;
        w_latched_nxt    = r_latched;
        w_long_nxt       = r_long;
        w_no_crc_nxt     = r_no_crc;
        w_tx_sr_nxt      = r_tx_sr;
        w_crc_nxt        = r_crc;
        w_sd_cmd_nxt     = r_sd_cmd;
        w_sd_cmd_en_nxt  = r_sd_cmd_en;

        case (r_state)
            ST_IDLE: begin
                if (clk_en_p_i && !sd_cmd_i) begin
                    w_rx_sr_nxt   = {r_rx_sr[46:0], 1'b0};
                    w_bit_cnt_nxt = 8'd1;
                    w_state_nxt   = ST_RX;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_RX: begin
                if (clk_en_p_i) begin
                    w_rx_sr_nxt   = {r_rx_sr[46:0], sd_cmd_i};
                    w_bit_cnt_nxt = r_bit_cnt + 8'd1;
                    if (r_bit_cnt == 8'd47) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_RX;
                    end
                end else begin
                    w_state_nxt = ST_RX;
                end
            end

            ST_CHECK: begin
                if (w_frame_ok) begin
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_nxt       = r_rx_sr[45:40];
                    w_arg_nxt       = r_rx_sr[39:8];
                    w_dly_cnt_nxt   = 7'd0;
                    w_bit_cnt_nxt   = 8'd0;
                    w_rsp_ready_nxt = 1'b1;
                    w_latched_nxt   = 1'b0;
                    w_state_nxt     = ST_WAIT_RSP;
                end else begin
                    w_cmd_err_nxt   = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end

            ST_WAIT_RSP: begin
                if (w_hs) begin
                    w_latched_nxt   = 1'b1;
                    w_rsp_ready_nxt = 1'b0;
                    w_long_nxt      = rsp_long_i;
                    w_no_crc_nxt    = rsp_no_crc_i;
                    w_crc_nxt       = 7'h00;
                    if (rsp_long_i) begin
                        w_tx_sr_nxt = {2'b00, 6'h3F, rsp_i};
                    end else begin
                        w_tx_sr_nxt = {2'b00, rsp_i[37:32], rsp_i[31:0], 88'd0};
                    end
                end else begin
                    w_latched_nxt   = r_latched;
                end

                // Delay counter saturates so a late handshake still sees counter >= RSP_DELAY
                if (clk_en_p_i && (r_dly_cnt != LP_TIMEOUT)) begin
                    w_dly_cnt_nxt = r_dly_cnt + 7'd1;
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt;
                end

                if (r_latched && (r_dly_cnt >= LP_DELAY) && clk_en_n_i) begin
                    // Start bit goes out on this strobe; r_bit_cnt is 0 here
                    w_sd_cmd_nxt    = w_tx_bit;
                    w_sd_cmd_en_nxt = 1'b1;
                    w_tx_sr_nxt     = w_tx_sr_shift;
                    w_crc_nxt       = w_crc_upd;
                    w_bit_cnt_nxt   = 8'd1;
                    w_state_nxt     = ST_TX;
                end else if (clk_en_p_i && !r_latched && !w_hs &&
                             (r_dly_cnt == (LP_TIMEOUT - 7'd1))) begin
                    w_timeout_nxt   = 1'b1;
                    w_rsp_ready_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt     = ST_WAIT_RSP;
                end
            end

            ST_TX: begin
                if (clk_en_n_i) begin
                    if (r_bit_cnt == w_frame_len) begin
                        w_sd_cmd_en_nxt = 1'b0;
                        w_sd_cmd_nxt    = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_sd_cmd_nxt    = w_tx_bit;
                        w_sd_cmd_en_nxt = 1'b1;
                        w_tx_sr_nxt     = w_tx_sr_shift;
                        w_crc_nxt       = w_crc_upd;
                        w_bit_cnt_nxt   = r_bit_cnt + 8'd1;
                        w_state_nxt     = ST_TX;
                    end
                end else begin
                    w_state_nxt = ST_TX;
                end
            end

            default: begin
                w_sd_cmd_en_nxt = 1'b0;
                w_sd_cmd_nxt    = 1'b1;
                w_rsp_ready_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 8'd0;
            r_dly_cnt    <= 7'd0;
            r_rx_sr      <= 48'd0;
            r_cmd        <= 6'd0;
            r_arg        <= 32'd0;
            r_cmd_valid  <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_timeout    <= 1'b0;
            r_rsp_ready  <= 1'b0;
            r_latched    <= 1'b0;
            r_long       <= 1'b0;
            r_no_crc     <= 1'b0;
            r_tx_sr      <= 128'd0;
            r_crc        <= 7'd0;
            r_sd_cmd     <= 1'b1;
            r_sd_cmd_en  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_dly_cnt    <= w_dly_cnt_nxt;
            r_rx_sr      <= w_rx_sr_nxt;
            r_cmd        <= w_cmd_nxt;
            r_arg        <= w_arg_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_timeout    <= w_timeout_nxt;
            r_rsp_ready  <= w_rsp_ready_nxt;
            r_latched    <= w_latched_nxt;
            r_long       <= w_long_nxt;
            r_no_crc     <= w_no_crc_nxt;
            r_tx_sr      <= w_tx_sr_nxt;
            r_crc        <= w_crc_nxt;
            r_sd_cmd     <= w_sd_cmd_nxt;
            r_sd_cmd_en  <= w_sd_cmd_en_nxt;
        end
    end

    assign sd_cmd_o      = r_sd_cmd;
    assign sd_cmd_en_o   = r_sd_cmd_en;
    assign cmd_valid_o   = r_cmd_valid;
    assign cmd_err_o     = r_cmd_err;
    assign cmd_o         = r_cmd;
    assign cmd_arg_o     = r_arg;
    assign rsp_ready_o   = r_rsp_ready;
    assign rsp_timeout_o = r_timeout;

endmodule
